// File: rtl/fifo_param_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_param_pkg
// Description : Shared types for the parametrised synchronous FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_param_pkg;

    // Accepted operation in one cycle, encoded as {read, write}
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_WR    = 2'b01,
        OP_RD    = 2'b10,
        OP_WR_RD = 2'b11
    } fifo_op_e;

    function automatic fifo_op_e decode_op(input logic wr_acc, input logic rd_acc);
        return fifo_op_e'({rd_acc, wr_acc});
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_param_defs.vh
// ============================================================================
// File        : fifo_param_defs.vh
// Description : Derived sizes and parameter legality checks for fifo_param.
// Revision    : 1.0 - initial release
// ============================================================================
localparam int DEPTH = 1 << DEPTH_LOG2;
localparam int CNT_W = DEPTH_LOG2 + 1;

generate
    if (DEPTH_LOG2 < 1) begin : g_bad_depth
        $error("fifo_param: DEPTH_LOG2 must be at least 1");
    end
    if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
        $error("fifo_param: AF_LEVEL must lie in 1..DEPTH");
    end
    if ((AE_LEVEL < 0) || (AE_LEVEL > DEPTH - 1)) begin : g_bad_ae
        $error("fifo_param: AE_LEVEL must lie in 0..DEPTH-1");
    end
endgenerate

// File: rtl/fifo_param_ram.sv
`default_nettype none
// ============================================================================
// Module      : fifo_param_ram
// Description : WIDTH x 2**DEPTH_LOG2 storage, sync write, registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_param_ram #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_waddr,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic                  i_re,
    input  logic [DEPTH_LOG2-1:0] i_raddr,
    output logic [WIDTH-1:0]      o_rdata
);

    localparam int c_DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0] r_mem [c_DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Array is deliberately left unreset so it can map onto block RAM
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : fifo_param
// Description : Single-clock FIFO with occupancy count, programmable
//               almost-full/almost-empty, flush and sticky error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_param
    import fifo_param_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int AF_LEVEL   = 14,
    parameter int AE_LEVEL   = 2
) (
    input  logic                ck,
    input  logic                rst,
    input  logic [WIDTH-1:0]    Din,
    input  logic                Wen,
    input  logic                Ren,
    input  logic                flush,
    output logic [WIDTH-1:0]    Dout,
    output logic                Dvalid,
    output logic                Fempty,
    output logic                Ffull,
    output logic                Fafull,
    output logic                Faempty,
    output logic [DEPTH_LOG2:0] Fcount,
    output logic                Fovf,
    output logic                Fudf
);

`include "fifo_param_defs.vh"

    localparam logic [CNT_W-1:0]      c_CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]      c_AF       = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0]      c_AE       = CNT_W'(AE_LEVEL);
    localparam logic [CNT_W-1:0]      c_CNT_ONE  = CNT_W'(1);
    localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE  = DEPTH_LOG2'(1);

    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2-1:0] r_rptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_empty;
    logic                  r_full;
    logic                  r_afull;
    logic                  r_aempty;
    logic                  r_dvalid;
    logic                  r_ovf;
    logic                  r_udf;

    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [CNT_W-1:0]      w_count_nxt;
    fifo_op_e              w_op;
    logic [WIDTH-1:0]      w_rdata;

    // Acceptance uses the registered flags, so a read never targets a word
    // being written in the same cycle.
    assign w_wr_acc = Wen & ~r_full  & ~flush & ~rst;
    assign w_rd_acc = Ren & ~r_empty & ~flush & ~rst;

    always_comb begin
        w_op        = decode_op(w_wr_acc, w_rd_acc);
        w_count_nxt = r_count;
        case (w_op)
            OP_WR:   w_count_nxt = r_count + c_CNT_ONE;
            OP_RD:   w_count_nxt = r_count - c_CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
            r_dvalid <= 1'b0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else if (flush) begin
            // Error history survives a flush; only rst clears it
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
            r_dvalid <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
            r_count  <= w_count_nxt;
            r_empty  <= (w_count_nxt == '0);
            r_full   <= (w_count_nxt == c_CNT_FULL);
            r_afull  <= (w_count_nxt >= c_AF);
            r_aempty <= (w_count_nxt <= c_AE);
            r_dvalid <= w_rd_acc;
            if (Wen && r_full) begin
                r_ovf <= 1'b1;
            end
            if (Ren && r_empty) begin
                r_udf <= 1'b1;
            end
        end
    end

    fifo_param_ram #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk     (ck),
        .rst     (rst),
        .i_we    (w_wr_acc),
        .i_waddr (r_wptr),
        .i_wdata (Din),
        .i_re    (w_rd_acc),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );

    assign Dout    = w_rdata;
    assign Dvalid  = r_dvalid;
    assign Fempty  = r_empty;
    assign Ffull   = r_full;
    assign Fafull  = r_afull;
    assign Faempty = r_aempty;
    assign Fcount  = r_count;
    assign Fovf    = r_ovf;
    assign Fudf    = r_udf;

endmodule
`default_nettype wire

// File: doc/fifo_param.md
Name: fifo_param

Overview:
Parametrised successor to the team's fixed 8-bit × 16-entry synchronous FIFO. Width and depth are generic. Adds an occupancy count, programmable almost-full/almost-empty flags, synchronous flush, a read-data-valid strobe, and sticky overflow/underflow error flags. It is a single-clock buffer between a producer and a consumer in the same clock domain. Read data is registered, as in the previous generation.

Parameters:
WIDTH, 8, data width in bits
DEPTH_LOG2, 4, log2 of entry count (DEPTH = 2**DEPTH_LOG2 = 16); must be ≥ 1
AF_LEVEL, 14, Fafull asserted when count ≥ AF_LEVEL; range 1..DEPTH
AE_LEVEL, 2, Faempty asserted when count ≤ AE_LEVEL; range 0..DEPTH-1

Ports:
ck  input  1  clock; all state updates on posedge
rst  input  1  synchronous, active-high reset
Din  input  WIDTH  write data
Wen  input  1  write request
Ren  input  1  read request
flush  input  1  synchronous discard of all contents
Dout  output  WIDTH  registered read data; holds last value read
Dvalid  output  1  one-cycle pulse: Dout updated by the previous edge
Fempty  output  1  count == 0
Ffull  output  1  count == DEPTH
Fafull  output  1  count ≥ AF_LEVEL
Faempty  output  1  count ≤ AE_LEVEL
Fcount  output  DEPTH_LOG2+1  current occupancy, 0..DEPTH
Fovf  output  1  sticky: a write was attempted while full
Fudf  output  1  sticky: a read was attempted while empty

Behaviour:
- Clock and reset: one clock, ck. Reset rst is synchronous and active-high.
- Reset (rst=1 at an edge) sets:
  - write and read pointers = 0, Fcount = 0
  - Fempty = 1, Ffull = 0, Faempty = 1, Fafull = 0
  - Dout = 0, Dvalid = 0, Fovf = 0, Fudf = 0
  - Memory contents are not reset.
  - Reset overrides flush, Wen and Ren in the same cycle, including mid-stream.
- Accept rules, evaluated on the flag values before the edge:
  - A write is accepted when Wen=1 and Ffull=0. The memory is written at the write pointer, and the write pointer increments.
  - A read is accepted when Ren=1 and Fempty=0. Dout takes the entry at the read pointer, the read pointer increments, and Dvalid=1 on the following cycle.
  - Dvalid is 0 in every cycle that follows an edge with no accepted read.
- Latency:
  - Read data appears on Dout one edge after the accepting edge.
  - A written word is readable at the next edge: Fempty falls at the write edge.
  - There is no fall-through. A write and a read of the same entry never occur in the same cycle, because the read needs Fempty=0 beforehand.
- Simultaneous Wen and Ren:
  - Neither full nor empty: both are accepted and Fcount is unchanged.
  - Full: only the read is accepted and Fcount decrements. The rejected write sets Fovf.
  - Empty: only the write is accepted and Fcount increments. The rejected read sets Fudf.
- Count arithmetic: Fcount becomes Fcount + accepted write − accepted read. Flags are registered and updated in the same edge as Fcount, so they always agree with it.
- Wrap-around: pointers are DEPTH_LOG2 bits and wrap naturally from DEPTH−1 to 0. Full and empty are distinguished by Fcount, not by pointer comparison.
- Flush (flush=1, rst=0):
  - pointers and Fcount go to 0, Fempty=1, Ffull=0, Faempty=1, Fafull=0
  - Wen and Ren in that cycle are ignored; Dvalid=0 next cycle
  - Dout holds its value
  - Fovf and Fudf are unaffected
- Error flags: Fovf and Fudf are sticky and are cleared only by rst.
- No state machine beyond the pointer/count datapath; all outputs are registered.

Decomposition:
- Shared include fifo_param_defs.vh holds:
  - derived localparams: DEPTH = 1<<DEPTH_LOG2, CNT_W = DEPTH_LOG2+1
  - parameter-legality checks (AF_LEVEL, AE_LEVEL ranges); an elaboration-time error on violation
- One sub-module, fifo_param_ram:
  - WIDTH × DEPTH array
  - synchronous write port
  - synchronous registered read port with read enable
  - no reset of the array

Test Plan:
1. Reset/idle: rst=1 for 2 cycles with Wen=Ren=1 → Fcount=0, Fempty=1, Faempty=1, Ffull=0, Fafull=0, Dout=0, Dvalid=0, Fovf=Fudf=0.
2. Fill/overflow: 17 consecutive writes of 0x01..0x11 with defaults →
   - Fafull rises after the 14th write, Ffull after the 16th
   - the 17th write is rejected, Fovf=1, Fcount=16
   - 16 reads then return 0x01..0x10 in order, each with a Dvalid pulse
3. Drain/underflow: from empty, write 0xA5, then issue 2 reads →
   - Dout=0xA5 with Dvalid=1, Fempty=1
   - the second read sets Fudf=1, Dvalid=0, and Dout stays 0xA5
4. Simultaneous at the boundaries:
   - Full with Wen=Ren=1 → Fcount 16→15, Ffull=0, Fovf=1, written data discarded.
   - Empty with Wen=Ren=1 (Din=0x3C) → Fcount 0→1, Fudf=1, a later read gives 0x3C.
   - Half-full (8) with Wen=Ren=1 for 20 cycles → Fcount stays 8 and pointers wrap correctly (data order preserved).
5. Flush:
   - Flush with Fcount=9 and Wen=Ren=1 → next cycle Fcount=0, Fempty=1, Dout unchanged, Dvalid=0, Fovf/Fudf unchanged.
   - After that, write 0x77 and read → 0x77.
6. Parametric and random:
   - WIDTH=16, DEPTH_LOG2=3, AF_LEVEL=6, AE_LEVEL=1: 10,000 cycles of random Wen/Ren/Din compared against a behavioural queue model, checking Dout, Dvalid, all flags and Fcount every edge.
   - Also run at DEPTH_LOG2=1.
